// File: rtl/cba_sg_write_arbiter.sv
// Round-robin write arbiter: N_REQ staging buffers share one latency-memory
// write port. Each requester owns a 2-entry {map, ts} holding queue; queues
// are granted round-robin into a single registered output with valid/ready.
// Maps arriving at a full queue are dropped and counted per requester.
module cba_sg_write_arbiter #(
  parameter  int N_REQ = 4,
  parameter  int MAP_W = 16,
  parameter  int TS_W  = 8,
  parameter  int CNT_W = 8,
  localparam int SRC_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TS_W-1:0]          ts,
  input  logic [N_REQ-1:0]         req_write,
  input  logic [N_REQ*MAP_W-1:0]   req_map,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [MAP_W-1:0]         out_map,
  output logic [TS_W-1:0]          out_ts,
  output logic [SRC_W-1:0]         out_src,
  output logic [N_REQ-1:0]         ovf,
  output logic [N_REQ*CNT_W-1:0]   ovf_cnt,
  input  logic                     clr_cnt,
  output logic                     busy
);

  typedef struct packed {
    logic [MAP_W-1:0] map;
    logic [TS_W-1:0]  ts;
  } entry_t;

  localparam logic [1:0] Q_DEPTH = 2'd2;

  // Queue storage: slot 0 is always the head of the FIFO.
  entry_t     q_data     [N_REQ][2];
  entry_t     q_data_nxt [N_REQ][2];
  logic [1:0] q_cnt      [N_REQ];
  logic [1:0] q_cnt_nxt  [N_REQ];
  entry_t     new_entry  [N_REQ];

  logic [N_REQ-1:0] nonempty;
  logic [N_REQ-1:0] pop;
  logic [N_REQ-1:0] push;
  logic [N_REQ-1:0] drop;

  logic [SRC_W-1:0] rr;
  logic [SRC_W-1:0] rr_nxt;
  logic [SRC_W-1:0] gnt_idx;
  logic             gnt_found;
  logic             load;
  logic             grant;

  // Occupancy flags and the entry each requester would push this cycle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      nonempty[i]  = (q_cnt[i] != 2'd0);
      new_entry[i] = '{map: req_map[i*MAP_W +: MAP_W], ts: ts};
    end
  end

  // Round-robin search starting at rr; the output register loads whenever
  // it is empty or being drained this cycle.
  always_comb begin
    int               cand;
    logic [SRC_W-1:0] idx;
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise an always_comb path that skips it would infer a latch.
    load      = !out_valid || out_ready;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    idx       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr) + k) % N_REQ;
      idx  = SRC_W'(cand);
      if (!gnt_found && nonempty[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx;
      end
    end
    grant  = load && gnt_found;
    rr_nxt = rr;
    if (grant) begin
      rr_nxt = (gnt_idx == SRC_W'(N_REQ - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end

  // Per-requester pop/push/drop: a full queue accepts a push only when its
  // head is popped in the same cycle.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      pop[i]  = grant && (gnt_idx == SRC_W'(i));
      push[i] = req_write[i] && ((q_cnt[i] != Q_DEPTH) || pop[i]);
      drop[i] = req_write[i] && !((q_cnt[i] != Q_DEPTH) || pop[i]);
    end
  end

  // Next queue contents: pop shifts slot 1 to the head, then a push lands in
  // the first free slot after the pop.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      q_data_nxt[i][0] = q_data[i][0];
      q_data_nxt[i][1] = q_data[i][1];
      q_cnt_nxt[i]     = q_cnt[i];
      if (pop[i]) begin
        q_data_nxt[i][0] = q_data[i][1];
        q_cnt_nxt[i]     = q_cnt[i] - 2'd1;
      end
      if (push[i]) begin
        if (q_cnt_nxt[i] == 2'd0) begin
          q_data_nxt[i][0] = new_entry[i];
        end else begin
          q_data_nxt[i][1] = new_entry[i];
        end
        q_cnt_nxt[i] = q_cnt_nxt[i] + 2'd1;
      end
    end
  end

  // Queue occupancy and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        q_cnt[i] <= 2'd0;
      end
      rr <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        q_cnt[i] <= q_cnt_nxt[i];
      end
      rr <= rr_nxt;
    end
  end

  // Queue payload storage.
  // NOTE: the payload is not reset; q_cnt alone says which slots are valid,
  // so clearing the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      q_data[i][0] <= q_data_nxt[i][0];
      q_data[i][1] <= q_data_nxt[i][1];
    end
  end

  // Output register: load the granted head, clear valid when draining with
  // nothing to grant, hold everything while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_map   <= '0;
      out_ts    <= '0;
      out_src   <= '0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_map   <= q_data[gnt_idx][0].map;
      out_ts    <= q_data[gnt_idx][0].ts;
      out_src   <= gnt_idx;
    end else if (load) begin
      out_valid <= 1'b0;
    end
  end

  // Drop pulse and saturating drop counters; a clear that coincides with a
  // drop leaves the counter at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf     <= '0;
      ovf_cnt <= '0;
    end else begin
      ovf <= drop;
      for (int i = 0; i < N_REQ; i++) begin
        if (clr_cnt) begin
          ovf_cnt[i*CNT_W +: CNT_W] <= drop[i] ? CNT_W'(1) : '0;
        end else if (drop[i] && (ovf_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          ovf_cnt[i*CNT_W +: CNT_W] <= ovf_cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

  // Activity flag from registered state only.
  always_comb begin
    busy = out_valid || (|nonempty);
  end

endmodule

// File: tb/tb_cba_sg_write_arbiter.sv
// Self-checking bench for cba_sg_write_arbiter: table-driven single writes,
// hand-written multi-cycle sequences, and a scoreboard that checks every
// transfer on the output port in the expected order.
module tb_cba_sg_write_arbiter;

  localparam int N_REQ = 4;
  localparam int MAP_W = 16;
  localparam int TS_W  = 8;
  localparam int CNT_W = 8;

  logic                   clk;
  logic                   reset;
  logic [TS_W-1:0]        ts;
  logic [N_REQ-1:0]       req_write;
  logic [N_REQ*MAP_W-1:0] req_map;
  logic                   out_ready;
  logic                   out_valid;
  logic [MAP_W-1:0]       out_map;
  logic [TS_W-1:0]        out_ts;
  logic [1:0]             out_src;
  logic [N_REQ-1:0]       ovf;
  logic [N_REQ*CNT_W-1:0] ovf_cnt;
  logic                   clr_cnt;
  logic                   busy;

  cba_sg_write_arbiter #(
    .N_REQ(N_REQ), .MAP_W(MAP_W), .TS_W(TS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .ts(ts), .req_write(req_write),
    .req_map(req_map), .out_ready(out_ready), .out_valid(out_valid),
    .out_map(out_map), .out_ts(out_ts), .out_src(out_src), .ovf(ovf),
    .ovf_cnt(ovf_cnt), .clr_cnt(clr_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] map;
    logic [7:0]  ts;
    logic [1:0]  src;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Single-write vectors: requester, map, timestamp and the expected output.
  typedef struct {
    int unsigned r;
    logic [15:0] map;
    logic [7:0]  ts;
    logic [1:0]  exp_src;
    logic [15:0] exp_map;
    logic [7:0]  exp_ts;
  } vec_t;

  vec_t        vecs[4];
  logic [15:0] bp_maps[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_push(input logic [15:0] m, input logic [7:0] t, input logic [1:0] s);
    exp_t e;
    e.map = m;
    e.ts  = t;
    e.src = s;
    sb.push_back(e);
  endtask

  task automatic set_map(input int r, input logic [15:0] m);
    req_map[r*MAP_W +: MAP_W] = m;
  endtask

  task automatic clear_writes();
    req_write = '0;
    req_map   = '0;
    clr_cnt   = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy) break;
      tick();
    end
    check("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // Scoreboard: a transfer happens at the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got map %0h src %0d expected no transfer", out_map, out_src);
      end else begin
        mon_e = sb.pop_front();
        check("sb_map", 32'(out_map), 32'(mon_e.map));
        check("sb_ts",  32'(out_ts),  32'(mon_e.ts));
        check("sb_src", 32'(out_src), 32'(mon_e.src));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{r: 1, map: 16'h0000, ts: 8'h40, exp_src: 2'd1, exp_map: 16'h0000, exp_ts: 8'h40};
    vecs[1] = '{r: 2, map: 16'hFFFF, ts: 8'h41, exp_src: 2'd2, exp_map: 16'hFFFF, exp_ts: 8'h41};
    vecs[2] = '{r: 0, map: 16'h1234, ts: 8'h42, exp_src: 2'd0, exp_map: 16'h1234, exp_ts: 8'h42};
    vecs[3] = '{r: 3, map: 16'h8001, ts: 8'hFF, exp_src: 2'd3, exp_map: 16'h8001, exp_ts: 8'hFF};
    bp_maps[0] = 16'h0011;
    bp_maps[1] = 16'h0022;
    bp_maps[2] = 16'h0033;
    bp_maps[3] = 16'h0044;

    reset     = 1'b1;
    ts        = '0;
    out_ready = 1'b1;
    clear_writes();

    // Reset state.
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_map",   32'(out_map),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_ovf",       32'(ovf),       32'd0);
    check("rst_ovf_cnt",   ovf_cnt,        32'd0);
    #20 reset = 1'b0;
    tick();
    tick();

    // Single write with minimum latency.
    set_map(0, 16'h00A5);
    ts        = 8'h10;
    req_write = 4'b0001;
    exp_push(16'h00A5, 8'h10, 2'd0);
    tick();
    clear_writes();
    check("sw_valid_c1", 32'(out_valid), 32'd0);
    check("sw_busy_c1",  32'(busy),      32'd1);
    tick();
    check("sw_valid_c2", 32'(out_valid), 32'd1);
    check("sw_map_c2",   32'(out_map),   32'h00A5);
    check("sw_ts_c2",    32'(out_ts),    32'h10);
    check("sw_src_c2",   32'(out_src),   32'd0);
    tick();
    check("sw_valid_c3", 32'(out_valid), 32'd0);
    check("sw_busy_c3",  32'(busy),      32'd0);

    // Table-driven single writes from every requester.
    for (int v = 0; v < 4; v++) begin
      set_map(int'(vecs[v].r), vecs[v].map);
      ts = vecs[v].ts;
      req_write = 4'(1 << vecs[v].r);
      exp_push(vecs[v].exp_map, vecs[v].exp_ts, vecs[v].exp_src);
      tick();
      clear_writes();
      check("vec_valid_c1", 32'(out_valid), 32'd0);
      tick();
      check("vec_valid_c2", 32'(out_valid), 32'd1);
      check("vec_src_c2",   32'(out_src),   32'(vecs[v].exp_src));
      check("vec_map_c2",   32'(out_map),   32'(vecs[v].exp_map));
      check("vec_ts_c2",    32'(out_ts),    32'(vecs[v].exp_ts));
      check("vec_ovf",      32'(ovf),       32'd0);
      tick();
      check("vec_valid_c3", 32'(out_valid), 32'd0);
    end

    // Round robin: two identical 4-way bursts, each delivered 0,1,2,3.
    for (int b = 0; b < 2; b++) begin
      req_map   = {16'h0008, 16'h0004, 16'h0002, 16'h0001};
      ts        = 8'(8'h20 + b);
      req_write = 4'b1111;
      for (int k = 0; k < 4; k++) exp_push(16'(1 << k), 8'(8'h20 + b), 2'(k));
      tick();
      clear_writes();
      tick();
      for (int k = 0; k < 4; k++) begin
        check("rr_valid", 32'(out_valid), 32'd1);
        check("rr_src",   32'(out_src),   32'(k));
        tick();
      end
      check("rr_valid_end", 32'(out_valid), 32'd0);
    end

    // Back-pressure: four writes into a stalled port, the fourth dropped.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_map(2, bp_maps[k]);
      ts        = 8'(8'h30 + k);
      req_write = 4'b0100;
      if (k < 3) exp_push(bp_maps[k], 8'(8'h30 + k), 2'd2);
      tick();
      if (k < 3) check("bp_ovf_none", 32'(ovf), 32'd0);
    end
    check("bp_ovf_pulse", 32'(ovf), 32'b0100);
    check("bp_ovf_cnt2",  32'(ovf_cnt[2*CNT_W +: CNT_W]), 32'd1);
    clear_writes();
    tick();
    check("bp_ovf_clear",  32'(ovf), 32'd0);
    check("bp_cnt_hold",   32'(ovf_cnt[2*CNT_W +: CNT_W]), 32'd1);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_map",   32'(out_map), 32'h0011);
    out_ready = 1'b1;
    wait_idle(20);

    // Full queue popped in the same cycle as a new write accepts it.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_map(1, 16'(16'h0070 + k));
      ts        = 8'(8'h40 + k);
      req_write = 4'b0010;
      exp_push(16'(16'h0070 + k), 8'(8'h40 + k), 2'd1);
      tick();
    end
    check("pf_full_ovf", 32'(ovf), 32'd0);
    set_map(1, 16'h007F);
    ts        = 8'h43;
    req_write = 4'b0010;
    out_ready = 1'b1;
    exp_push(16'h007F, 8'h43, 2'd1);
    tick();
    clear_writes();
    check("pf_no_drop", 32'(ovf), 32'd0);
    check("pf_cnt1",    32'(ovf_cnt[1*CNT_W +: CNT_W]), 32'd0);
    check("pf_out_map", 32'(out_map), 32'h0071);
    wait_idle(20);

    // Counter saturation after 300 drops, then clear with a coincident drop.
    out_ready = 1'b0;
    for (int k = 0; k < 303; k++) begin
      set_map(3, 16'(16'h3000 + k));
      ts        = 8'(k);
      req_write = 4'b1000;
      if (k < 3) exp_push(16'(16'h3000 + k), 8'(k), 2'd3);
      tick();
      if (k == 102) check("sat_cnt_100", 32'(ovf_cnt[3*CNT_W +: CNT_W]), 32'd100);
    end
    check("sat_cnt_255", 32'(ovf_cnt[3*CNT_W +: CNT_W]), 32'd255);
    check("sat_ovf",     32'(ovf), 32'b1000);
    clr_cnt = 1'b1;
    tick();
    check("clr_with_drop", ovf_cnt, 32'h0100_0000);
    clear_writes();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_alone", ovf_cnt, 32'd0);
    out_ready = 1'b1;
    wait_idle(20);

    // Reset mid-operation: in-flight entries are discarded.
    out_ready = 1'b0;
    req_map   = {16'h0000, 16'h0053, 16'h0052, 16'h0051};
    ts        = 8'h60;
    req_write = 4'b0111;
    tick();
    clear_writes();
    tick();
    check("mr_pre_valid", 32'(out_valid), 32'd1);
    check("mr_pre_busy",  32'(busy),      32'd1);
    #2 reset = 1'b1;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_map",   32'(out_map),   32'd0);
    check("mr_ts",    32'(out_ts),    32'd0);
    check("mr_src",   32'(out_src),   32'd0);
    check("mr_busy",  32'(busy),      32'd0);
    check("mr_cnt",   ovf_cnt,        32'd0);
    #3 reset = 1'b0;
    tick();
    out_ready = 1'b1;
    req_map   = {16'h0000, 16'h0063, 16'h0000, 16'h0061};
    ts        = 8'h70;
    req_write = 4'b0101;
    exp_push(16'h0061, 8'h70, 2'd0);
    exp_push(16'h0063, 8'h70, 2'd2);
    tick();
    clear_writes();
    check("mr_after_c1", 32'(out_valid), 32'd0);
    tick();
    check("mr_after_valid", 32'(out_valid), 32'd1);
    check("mr_after_src",   32'(out_src),   32'd0);
    wait_idle(20);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cba_sg_write_arbiter.md
# cba_sg_write_arbiter

Round-robin write arbiter that shares one latency-memory write port among `N_REQ` core-region staging buffers. Each requester pulses its write strobe with a hit map when a staging line reaches its output slot. The block captures the map and timestamp into a per-requester 2-entry holding queue and grants the queues in round-robin order into a single output register with valid/ready back-pressure. Maps that arrive at a full queue are dropped, and the drops are counted per requester.

## Interface
Parameters:
- `N_REQ`, 4, number of staging-buffer requesters (2..8)
- `MAP_W`, 16, hit-map width per requester
- `TS_W`, 8, timestamp width
- `CNT_W`, 8, overflow counter width per requester

Ports:
- `clk`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-high
- `ts`  in  `TS_W`  free-running timestamp, sampled with each accepted write
- `req_write`  in  `N_REQ`  per-requester write strobe, one map per high cycle
- `req_map`  in  `N_REQ*MAP_W`  hit maps; requester i occupies bits [i*MAP_W +: MAP_W]
- `out_ready`  in  1  memory port can accept the output register this cycle
- `out_valid`  out  1  output register holds a valid entry
- `out_map`  out  `MAP_W`  granted hit map
- `out_ts`  out  `TS_W`  timestamp captured when the map was pushed
- `out_src`  out  `$clog2(N_REQ)`  index of the granted requester
- `ovf`  out  `N_REQ`  one-cycle pulse: requester i's map was dropped
- `ovf_cnt`  out  `N_REQ*CNT_W`  saturating drop counters, requester i at [i*CNT_W +: CNT_W]
- `clr_cnt`  in  1  synchronous clear of all `ovf_cnt`
- `busy`  out  1  any queue non-empty or `out_valid` high

## Operation
- Per-requester queue: 2 entries of {map, ts}, FIFO order, with count values 0, 1 or 2.
- Push: on a clock edge with `req_write[i]`=1, push {`req_map` slice, `ts`} to queue i if there is space after this cycle's pop.
  - A full queue being popped in the same cycle accepts the push.
  - Otherwise the map is dropped, `ovf[i]` pulses for 1 cycle and `ovf_cnt[i]` increments.
- A write strobe carrying an all-zero map is still pushed. Filtering is not this block's job.
- Load condition: load = `!out_valid || out_ready`. When load is true and any queue is non-empty, grant one queue.
- Grant: pop that queue's head into {`out_map`, `out_ts`, `out_src`} and set `out_valid`=1.
- Load with all queues empty: `out_valid` goes to 0.
- `out_valid`=1 with `out_ready`=0: all output fields hold stable and no queue is popped.
- Round-robin pointer `rr`: search order is rr, rr+1, …, N_REQ-1, 0, …, rr-1; the first non-empty queue wins.
- After a grant to i, `rr` = (i+1) mod N_REQ. Without a grant, `rr` is unchanged.
- Counters: `ovf_cnt[i]` saturates at 2^CNT_W-1, with no wrap.
- `clr_cnt`=1 zeroes all counters. If `clr_cnt` and a drop coincide on requester i, `ovf_cnt[i]` becomes 1.
- `busy` = `out_valid` OR any queue count ≠ 0. It is combinational from registered state.
- Reset (asynchronous, any time including mid-transfer):
  - all queues empty, `rr`=0;
  - `out_valid`=0, `out_map`=0, `out_ts`=0, `out_src`=0;
  - `ovf`=0, all `ovf_cnt`=0, `busy`=0.
  - Entries in flight are discarded, with no drop counted.

## Timing
- Push visibility: a push at edge t is visible in the queue count after edge t.
- Minimum latency: `req_write` high in cycle c into an empty queue with a free output register gives `out_valid`=1 in cycle c+2.
  - Edge c: push.
  - Edge c+1: grant and load.
- Throughput: 1 entry per cycle while `out_ready`=1.
- Sustained input rate: one requester writing every cycle saturates its queue only if `out_ready` stalls or other requesters compete.
- `ovf` pulse timing: asserted in cycle c+1 for a drop at edge c. `ovf_cnt` updates at the same edge.
- Outputs: all outputs are registered except `busy`.
- No combinational path from `req_*` or `out_ready` to any output.

## Test plan
- **Single write:** reset, then `req_write`=0001, map 0x00A5, ts 0x10 in cycle 5 → cycle 7: `out_valid`=1, `out_map`=0x00A5, `out_ts`=0x10, `out_src`=0; cycle 8: `out_valid`=0, `busy`=0.
- **Round robin:** `req_write`=1111 for 1 cycle with maps 0x1,0x2,0x4,0x8, `out_ready`=1 → `out_src` sequence 0,1,2,3 on consecutive cycles. Repeat the burst → sequence starts again at 0 (rr=0 after src 3).
- **Back-pressure:** `out_ready`=0; requester 2 writes maps 0x11,0x22,0x33,0x44 on consecutive cycles → first held in the output register, next 2 queued, 4th dropped. `ovf[2]` pulses once and `ovf_cnt[2]`=1. Release ready → 0x11, 0x22, 0x33 in order.
- **Push on a popped full queue:** queue 1 full, `out_ready`=1 and queue 1 granted in the same cycle as a new write 0x7F → no drop, 0x7F delivered after the queued entries.
- **Counter saturation and clear:** force 300 drops on requester 3 with CNT_W=8 → `ovf_cnt[3]`=255. Pulse `clr_cnt` together with a drop → counter becomes 1.
- **Reset mid-operation:** assert `reset` while `out_valid`=1 and 2 queues are non-empty → all outputs 0 immediately. After release, the first write appears at +2 cycles with `out_src` chosen from rr=0.
